gcd_unit: RTL and testbench

//  Self-sequenced GCD engine: owns its FSM, operand registers and step counter.

---
 rtl/gcd_pkg.sv | 26 ++
 rtl/gcd_step.sv | 87 ++++++++
 rtl/gcd_unit.sv | 139 +++++++++++++
 tb/tb_gcd_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Purpose : Shared types and constants for the GCD engine.
//           - gcd_state_t : sequencing states of gcd_unit
//           - ALG_SUB / ALG_STEIN : values for the STEIN parameter
//           - k_width()   : width of the common-power-of-two exponent register
// Ports   : none (package)
// -----------------------------------------------------------------------------
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } gcd_state_t;

   localparam int ALG_SUB   = 0;
   localparam int ALG_STEIN = 1;

   // The exponent k only grows while both operands are even and non-zero,
   // so it never exceeds WIDTH-1; $clog2(WIDTH) bits are enough (min 1).
   function automatic int k_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/gcd_step.sv
// -----------------------------------------------------------------------------
// gcd_step
// Purpose : One combinational iteration of the GCD algorithm. Given the current
//           operand pair (x, y) and exponent k it produces the next pair and
//           exponent, plus the termination flags used by the sequencer.
// Params  : WIDTH - operand width
//           STEIN - ALG_SUB (subtractive) or ALG_STEIN (binary)
//           K_W   - width of the exponent k
// Ports   : i_x, i_y  in  WIDTH  current operands
//           i_k       in  K_W    current common power-of-two exponent
//           o_x, o_y  out WIDTH  operands after one step
//           o_k       out K_W    exponent after one step
//           o_eq      out 1      x == y
//           o_zero    out 1      x == 0 or y == 0
// -----------------------------------------------------------------------------
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEIN = ALG_SUB,
   parameter int K_W   = 3
) (
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic [K_W-1:0]   i_k,
   output logic [WIDTH-1:0] o_x,
   output logic [WIDTH-1:0] o_y,
   output logic [K_W-1:0]   o_k,
   output logic             o_eq,
   output logic             o_zero
);

   logic             w_x_gt_y;
   logic [WIDTH-1:0] w_diff_xy;
   logic [WIDTH-1:0] w_diff_yx;

   assign w_x_gt_y  = (i_x > i_y);
   // Only the difference matching the larger operand is ever selected,
   // so neither subtraction can underflow where it is used.
   assign w_diff_xy = i_x - i_y;
   assign w_diff_yx = i_y - i_x;

   assign o_eq   = (i_x == i_y);
   assign o_zero = (i_x == '0) || (i_y == '0);

   generate
      if (STEIN == ALG_STEIN) begin : g_stein
         logic w_x_even;
         logic w_y_even;

         assign w_x_even = ~i_x[0];
         assign w_y_even = ~i_y[0];

         always_comb begin
            o_x = i_x;
            o_y = i_y;
            o_k = i_k;
            if (w_x_even && w_y_even) begin
               // Common factor of two: strip it and remember it in k.
               o_x = i_x >> 1;
               o_y = i_y >> 1;
               o_k = i_k + 1'b1;
            end else if (w_x_even) begin
               o_x = i_x >> 1;
            end else if (w_y_even) begin
               o_y = i_y >> 1;
            end else if (w_x_gt_y) begin
               o_x = w_diff_xy;
            end else begin
               o_y = w_diff_yx;
            end
         end
      end else begin : g_sub
         always_comb begin
            o_x = i_x;
            o_y = i_y;
            o_k = i_k;
            if (w_x_gt_y) begin
               o_x = w_diff_xy;
            end else begin
               o_y = w_diff_yx;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/gcd_unit.sv
// -----------------------------------------------------------------------------
// gcd_unit
// Purpose : Self-sequenced GCD engine. Accepts an operand pair through a
//           valid/ready input handshake, iterates gcd_step once per cycle and
//           presents the result with its step count through a valid/ready
//           output handshake. A running computation can be cancelled.
// Params  : WIDTH - operand/result width (>= 2)
//           STEIN - ALG_SUB (subtractive) or ALG_STEIN (binary)
//           CNT_W - step counter width, saturating at 2**CNT_W-1
// Ports   : clk          in  1      rising-edge clock
//           rst_n        in  1      asynchronous active-low reset
//           i_in_valid   in  1      operand pair valid
//           o_in_ready   out 1      engine idle, can accept operands
//           i_a, i_b     in  WIDTH  operands
//           i_abort      in  1      cancel a running computation
//           o_out_valid  out 1      result valid
//           i_out_ready  in  1      sink accepts result
//           o_gcd        out WIDTH  result
//           o_steps      out CNT_W  iteration steps performed (saturating)
// -----------------------------------------------------------------------------
module gcd_unit
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEIN = ALG_SUB,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_abort,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_gcd,
   output logic [CNT_W-1:0] o_steps
);

   localparam int              K_W     = k_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   gcd_state_t       r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [K_W-1:0]   r_k;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_gcd;
   logic [CNT_W-1:0] r_steps;
   logic             r_out_valid;

   logic [WIDTH-1:0] w_x_next;
   logic [WIDTH-1:0] w_y_next;
   logic [K_W-1:0]   w_k_next;
   logic             w_eq;
   logic             w_zero;

   gcd_step #(
      .WIDTH (WIDTH),
      .STEIN (STEIN),
      .K_W   (K_W)
   ) u_step (
      .i_x    (r_x),
      .i_y    (r_y),
      .i_k    (r_k),
      .o_x    (w_x_next),
      .o_y    (w_y_next),
      .o_k    (w_k_next),
      .o_eq   (w_eq),
      .o_zero (w_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_k         <= '0;
         r_cnt       <= '0;
         r_gcd       <= '0;
         r_steps     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_in_valid) begin
                  r_x     <= i_a;
                  r_y     <= i_b;
                  r_k     <= '0;
                  r_cnt   <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               // Decision order matters: abort wins even over a pair that is
               // already finished, and the zero test precedes equality so
               // gcd(0,0) resolves to 0 through the OR.
               if (i_abort) begin
                  r_state <= IDLE;
               end else if (w_zero) begin
                  r_gcd       <= r_x | r_y;
                  r_steps     <= r_cnt;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else if (w_eq) begin
                  // k stays 0 for the subtractive variant; for Stein the
                  // shifted value is the true gcd, which fits in WIDTH bits.
                  r_gcd       <= r_x << r_k;
                  r_steps     <= r_cnt;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_x   <= w_x_next;
                  r_y   <= w_y_next;
                  r_k   <= w_k_next;
                  r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = (r_state == IDLE);
   assign o_out_valid = r_out_valid;
   assign o_gcd       = r_gcd;
   assign o_steps     = r_steps;

endmodule

// File: tb/tb_gcd_unit.sv
// -----------------------------------------------------------------------------
// tb_gcd_unit
// Three engines: [0] subtractive, [1] Stein, [2] subtractive with a 4-bit
// step counter (exercises saturation). A behavioural model gives gcd (Euclid
// by modulo) and the raw step count (rule-level iteration on integers).
// -----------------------------------------------------------------------------
module tb_gcd_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid  [3];
   logic       abort_s   [3];
   logic       out_ready [3];
   logic [7:0] a_s       [3];
   logic [7:0] b_s       [3];
   logic       in_ready  [3];
   logic       out_valid [3];
   logic [7:0] gcd_o     [3];
   logic [7:0] steps0;
   logic [7:0] steps1;
   logic [3:0] steps2;

   int checks   = 0;
   int failures = 0;

   bit exp_valid [3];
   int exp_gcd   [3];
   int exp_steps [3];

   always #5 clk = ~clk;

   gcd_unit #(.WIDTH(8), .STEIN(0), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
      .i_a(a_s[0]), .i_b(b_s[0]), .i_abort(abort_s[0]), .o_out_valid(out_valid[0]),
      .i_out_ready(out_ready[0]), .o_gcd(gcd_o[0]), .o_steps(steps0));

   gcd_unit #(.WIDTH(8), .STEIN(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
      .i_a(a_s[1]), .i_b(b_s[1]), .i_abort(abort_s[1]), .o_out_valid(out_valid[1]),
      .i_out_ready(out_ready[1]), .o_gcd(gcd_o[1]), .o_steps(steps1));

   gcd_unit #(.WIDTH(8), .STEIN(0), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid[2]), .o_in_ready(in_ready[2]),
      .i_a(a_s[2]), .i_b(b_s[2]), .i_abort(abort_s[2]), .o_out_valid(out_valid[2]),
      .i_out_ready(out_ready[2]), .o_gcd(gcd_o[2]), .o_steps(steps2));

   function automatic int get_steps(input int idx);
      case (idx)
         0:       return int'(steps0);
         1:       return int'(steps1);
         default: return int'(steps2);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // gcd by Euclid's modulo method; steps by applying the iteration rules.
   function automatic void model(input int a, input int b, input int stein,
                                 output int g, output int raw_steps);
      int x, y, t;
      x = a; y = b;
      while (y != 0) begin
         t = x % y; x = y; y = t;
      end
      g = x;
      x = a; y = b; raw_steps = 0;
      while (x != 0 && y != 0 && x != y) begin
         if (stein != 0 && x % 2 == 0 && y % 2 == 0) begin
            x = x / 2; y = y / 2;
         end else if (stein != 0 && x % 2 == 0) begin
            x = x / 2;
         end else if (stein != 0 && y % 2 == 0) begin
            y = y / 2;
         end else if (x > y) begin
            x = x - y;
         end else begin
            y = y - x;
         end
         raw_steps++;
      end
   endfunction

   // Single compare process: whenever a result is presented it must match
   // the outstanding expectation, every cycle it is held.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            if (out_valid[i]) begin
               if (!exp_valid[i]) begin
                  check($sformatf("unexpected_out_valid_inst%0d", i), 1, 0);
               end else begin
                  check($sformatf("gcd_inst%0d", i), int'(gcd_o[i]), exp_gcd[i]);
                  check($sformatf("steps_inst%0d", i), get_steps(i), exp_steps[i]);
               end
            end
         end
      end
   end

   task automatic run_op(input int idx, input int a, input int b, input int hold,
                         output int g_o, output int s_o);
      int g, raw, smax, n;
      model(a, b, (idx == 1) ? 1 : 0, g, raw);
      smax = (idx == 2) ? 15 : 255;
      g_o = -1; s_o = -1;
      n = 0;
      while (!in_ready[idx] && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_before_accept", int'(in_ready[idx]), 1);
      a_s[idx] = 8'(a); b_s[idx] = 8'(b); in_valid[idx] = 1'b1;
      @(posedge clk); #1;
      in_valid[idx]  = 1'b0;
      exp_gcd[idx]   = g;
      exp_steps[idx] = (raw > smax) ? smax : raw;
      exp_valid[idx] = 1'b1;
      check("in_ready_after_accept", int'(in_ready[idx]), 0);
      n = 0;
      while (!out_valid[idx] && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      if (!out_valid[idx]) begin
         check("result_timeout", 0, 1);
         exp_valid[idx] = 1'b0;
         return;
      end
      // Result is registered on the edge after the final CALC decision:
      // raw+1 edges after the accept edge (raw+2 counting the accept edge).
      check("latency_edges", n, raw + 1);
      g_o = int'(gcd_o[idx]);
      s_o = get_steps(idx);
      for (int h = 0; h < hold; h++) begin
         a_s[idx] = 8'($urandom); b_s[idx] = 8'($urandom); in_valid[idx] = 1'b1;
         @(posedge clk); #1;
         check("in_ready_in_done", int'(in_ready[idx]), 0);
         check("out_valid_held", int'(out_valid[idx]), 1);
      end
      in_valid[idx]  = 1'b0;
      out_ready[idx] = 1'b1;
      @(posedge clk); #1;
      out_ready[idx] = 1'b0;
      exp_valid[idx] = 1'b0;
      check("out_valid_after_handshake", int'(out_valid[idx]), 0);
      check("in_ready_after_handshake", int'(in_ready[idx]), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, s, ga, sa, ri;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; abort_s[i] = 1'b0; out_ready[i] = 1'b0;
         a_s[i] = '0; b_s[i] = '0; exp_valid[i] = 1'b0;
         exp_gcd[i] = 0; exp_steps[i] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("reset_gcd", int'(gcd_o[i]), 0);
         check("reset_steps", get_steps(i), 0);
         check("reset_out_valid", int'(out_valid[i]), 0);
         check("reset_in_ready", int'(in_ready[i]), 1);
      end
      @(negedge clk) rst_n = 1'b1;

      // Pin the model with hand-computed values.
      model(12, 8, 0, g, s);  check("model_sub_12_8_g", g, 4);  check("model_sub_12_8_s", s, 2);
      model(12, 8, 1, g, s);  check("model_st_12_8_g", g, 4);   check("model_st_12_8_s", s, 5);
      model(255, 1, 0, g, s); check("model_255_1_s", s, 254);
      model(9, 6, 0, g, s);   check("model_9_6_g", g, 3);

      // Directed cases; the first holds the result 10 cycles with in_valid poked.
      run_op(0, 12, 8, 10, g, s); check("sub_12_8_gcd", g, 4);  check("sub_12_8_steps", s, 2);
      $display("op inst0 a=12 b=8 gcd=%0d steps=%0d", g, s);
      run_op(1, 12, 8, 0, g, s);  check("st_12_8_gcd", g, 4);   check("st_12_8_steps", s, 5);
      $display("op inst1 a=12 b=8 gcd=%0d steps=%0d", g, s);
      run_op(0, 255, 1, 0, g, s); check("sub_255_1_gcd", g, 1); check("sub_255_1_steps", s, 254);
      $display("op inst0 a=255 b=1 gcd=%0d steps=%0d", g, s);
      run_op(0, 0, 9, 0, g, s);   check("sub_0_9_gcd", g, 9);   check("sub_0_9_steps", s, 0);
      $display("op inst0 a=0 b=9 gcd=%0d steps=%0d", g, s);
      run_op(0, 0, 0, 0, g, s);   check("sub_0_0_gcd", g, 0);
      $display("op inst0 a=0 b=0 gcd=%0d steps=%0d", g, s);
      run_op(1, 0, 0, 1, g, s);   check("st_0_0_gcd", g, 0);
      $display("op inst1 a=0 b=0 gcd=%0d steps=%0d", g, s);
      run_op(2, 255, 1, 0, g, s); check("sat_255_1_gcd", g, 1); check("sat_255_1_steps", s, 15);
      $display("op inst2 a=255 b=1 gcd=%0d steps=%0d", g, s);
      run_op(1, 128, 96, 0, g, s); check("st_128_96_gcd", g, 32);
      $display("op inst1 a=128 b=96 gcd=%0d steps=%0d", g, s);

      // Abort mid-computation: no result, registered outputs untouched.
      run_op(0, 9, 6, 0, ga, sa);
      a_s[0] = 8'd200; b_s[0] = 8'd3; in_valid[0] = 1'b1;
      @(posedge clk); #1; in_valid[0] = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      abort_s[0] = 1'b1;
      @(posedge clk); #1; abort_s[0] = 1'b0;
      check("abort_in_ready", int'(in_ready[0]), 1);
      check("abort_out_valid", int'(out_valid[0]), 0);
      check("abort_gcd_kept", int'(gcd_o[0]), ga);
      check("abort_steps_kept", get_steps(0), sa);
      $display("op inst0 a=200 b=3 aborted");
      repeat (5) begin @(posedge clk); #1; end
      run_op(0, 9, 6, 0, g, s);   check("after_abort_gcd", g, 3); check("after_abort_steps", s, 2);
      $display("op inst0 a=9 b=6 gcd=%0d steps=%0d", g, s);

      // Abort on the very cycle the pair is already equal: abort wins.
      a_s[0] = 8'd5; b_s[0] = 8'd5; in_valid[0] = 1'b1;
      @(posedge clk); #1; in_valid[0] = 1'b0; abort_s[0] = 1'b1;
      @(posedge clk); #1; abort_s[0] = 1'b0;
      check("abort_beats_done_in_ready", int'(in_ready[0]), 1);
      check("abort_beats_done_out_valid", int'(out_valid[0]), 0);
      $display("op inst0 a=5 b=5 aborted on equal");
      repeat (3) begin @(posedge clk); #1; end

      // Asynchronous reset in the middle of a long computation.
      a_s[0] = 8'd255; b_s[0] = 8'd1; in_valid[0] = 1'b1;
      @(posedge clk); #1; in_valid[0] = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check("midreset_gcd", int'(gcd_o[0]), 0);
      check("midreset_steps", get_steps(0), 0);
      check("midreset_out_valid", int'(out_valid[0]), 0);
      check("midreset_in_ready", int'(in_ready[0]), 1);
      $display("op inst0 a=255 b=1 reset mid-calc");
      @(negedge clk) rst_n = 1'b1;

      // Random sweep: 500 pairs on each algorithm, zeros injected.
      for (int n = 0; n < 1000; n++) begin
         int ra, rb;
         ri = n % 2;
         ra = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
         rb = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
         run_op(ri, ra, rb, int'($urandom_range(0, 2)), g, s);
         $display("op inst%0d a=%0d b=%0d gcd=%0d steps=%0d", ri, ra, rb, g, s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
